readout_queue_v3: RTL and testbench

- Parametrised successor readout queue between readout_comm (event block-address producer) and irs_block_readout / irs_block_manager.
- Buffers read addresses in a true FIFO of configurable depth and hands them one at a time to block readout with a strobe/done handshake.
- On completion, returns the freed block number to the block manager.
- Adds explicit full/empty, an occupancy count, a sticky overflow flag, a free-address strobe and a remaining flag computed from live occupancy.

---
 rtl/readout_queue_v3.sv | 230 +++++++++++++++++++++++
 tb/tb_readout_queue_v3.sv | 382 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/readout_queue_v3.sv
// readout_queue_v3
// FIFO of event block addresses sitting between readout_comm and block
// readout. Entries are handed out one at a time with a strobe/done
// handshake and the block number is returned to the block manager once
// readout of that entry has finished.
//
// Handshake summary (all strobes are single-cycle, registered pulses):
//   wea_from_readout_comm : one entry accepted per high cycle unless full;
//                           a dropped entry sets the sticky overflow flag.
//   read_strobe_o         : read_block_o / read_remaining_o are valid this
//                           cycle; block readout should start.
//   read_done_i           : only looked at while waiting for readout; any
//                           other time it is ignored.
//   free_strobe_o         : free_address_o carries the released block.
module readout_queue_v3 #(
  parameter int n_triggers      = 3,
  parameter int BLOCK_WIDTH     = 9,
  parameter int TIMESTAMP_WIDTH = 15,
  parameter int TRIG_WIDTH      = n_triggers + 1,
  parameter int RADDR_WIDTH     = TIMESTAMP_WIDTH + BLOCK_WIDTH + TRIG_WIDTH,
  parameter int RB_WIDTH        = RADDR_WIDTH,
  parameter int DEPTH_LOG2      = 9
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [RADDR_WIDTH-1:0] read_address_from_readout_comm,
  input  logic                   wea_from_readout_comm,
  output logic [RB_WIDTH-1:0]    read_block_o,
  output logic                   read_strobe_o,
  output logic                   read_remaining_o,
  input  logic                   read_done_i,
  output logic [BLOCK_WIDTH-1:0] free_address_o,
  output logic                   free_strobe_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [DEPTH_LOG2:0]    count_o,
  output logic                   overflow_o,
  output logic [2:0]             state_debug_o
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  // Occupancy constants sized to the count register.
  localparam logic [DEPTH_LOG2:0] C_CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] C_CNT_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] C_CNT_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_STROBE  = 3'd2,
    S_WAIT    = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  // Storage and pointers
  logic [RADDR_WIDTH-1:0] r_mem [DEPTH];
  logic [RADDR_WIDTH-1:0] r_rdata;
  logic [DEPTH_LOG2-1:0]  r_wr_ptr;
  logic [DEPTH_LOG2-1:0]  r_rd_ptr;
  logic [DEPTH_LOG2:0]    r_count;

  // Control state
  state_t                 r_state;
  state_t                 w_next_state;

  // Registered outputs
  logic [RADDR_WIDTH-1:0] r_head;
  logic                   r_read_strobe;
  logic                   r_remaining;
  logic                   r_free_strobe;
  logic [BLOCK_WIDTH-1:0] r_free_addr;
  logic                   r_overflow;

  // Decoded per-cycle actions
  logic w_full;
  logic w_empty;
  logic w_fetch;
  logic w_load_head;
  logic w_release;
  logic w_wr_en;
  logic w_drop;

  assign w_full  = (r_count == C_CNT_FULL);
  assign w_empty = (r_count == C_CNT_ZERO);

  // A release frees a slot in the same cycle, so a full queue can still
  // accept an entry while the head is being released.
  assign w_wr_en = wea_from_readout_comm && (!w_full || w_release);
  assign w_drop  = wea_from_readout_comm && w_full && !w_release;

  // Dual-port RAM: write on accepted enqueue, registered read during FETCH.
  // The read slot is always occupied and the write slot always empty, so
  // the two ports never address the same entry in one cycle.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= read_address_from_readout_comm;
    end
    if (w_fetch) begin
      r_rdata <= r_mem[r_rd_ptr];
    end
  end

  // Write pointer advances on every accepted entry and wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
    end else if (w_wr_en) begin
      r_wr_ptr <= r_wr_ptr + 1'b1;
    end
  end

  // Read pointer advances only when the head entry is released.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_ptr <= '0;
    end else if (w_release) begin
      r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Occupancy: enqueue and release in the same cycle cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else begin
      case ({w_wr_en, w_release})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow: any dropped entry is remembered until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM next-state and action decode.
  always_comb begin
    w_next_state = r_state;
    w_fetch      = 1'b0;
    w_load_head  = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_next_state = S_FETCH;
        end
      end
      S_FETCH: begin
        w_fetch      = 1'b1;
        w_next_state = S_STROBE;
      end
      S_STROBE: begin
        w_load_head  = 1'b1;
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (read_done_i) begin
          w_next_state = S_RELEASE;
        end
      end
      S_RELEASE: begin
        w_release    = 1'b1;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Head register and read-side outputs. The head and remaining flag are
  // captured in STROBE and held until the next STROBE; remaining uses the
  // occupancy of that cycle, which still includes the head itself.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head        <= '0;
      r_read_strobe <= 1'b0;
      r_remaining   <= 1'b0;
    end else begin
      r_read_strobe <= w_load_head;
      if (w_load_head) begin
        r_head      <= r_rdata;
        r_remaining <= (r_count > C_CNT_ONE);
      end
    end
  end

  // Free-side outputs: the released block number is presented with a
  // one-cycle strobe following the release.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_free_strobe <= 1'b0;
      r_free_addr   <= '0;
    end else begin
      r_free_strobe <= w_release;
      if (w_release) begin
        r_free_addr <= r_head[BLOCK_WIDTH-1:0];
      end
    end
  end

  assign read_block_o     = r_head[RB_WIDTH-1:0];
  assign read_strobe_o    = r_read_strobe;
  assign read_remaining_o = r_remaining;
  assign free_address_o   = r_free_addr;
  assign free_strobe_o    = r_free_strobe;
  assign full_o           = w_full;
  assign empty_o          = w_empty;
  assign count_o          = r_count;
  assign overflow_o       = r_overflow;
  assign state_debug_o    = r_state;

endmodule

// File: tb/tb_readout_queue_v3.sv
// Testbench for readout_queue_v3: a default-depth instance checked every
// cycle against a queue-level reference model, and a depth-4 instance
// driven by the same inputs for full/overflow/wrap scenarios.
module tb_readout_queue_v3;

  localparam int BW  = 9;
  localparam int RW  = 28;
  localparam int DL  = 9;
  localparam int DLS = 2;
  localparam int BIG_DEPTH = 1 << DL;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [RW-1:0] addr;
  logic          wea;
  logic          done;

  // default-depth instance
  logic [RW-1:0]  b_block;
  logic           b_strobe, b_rem, b_free_strobe, b_full, b_empty, b_ovf;
  logic [BW-1:0]  b_free_addr;
  logic [DL:0]    b_count;
  logic [2:0]     b_state;

  // depth-4 instance
  logic [RW-1:0]  s_block;
  logic           s_strobe, s_rem, s_free_strobe, s_full, s_empty, s_ovf;
  logic [BW-1:0]  s_free_addr;
  logic [DLS:0]   s_count;
  logic [2:0]     s_state;

  readout_queue_v3 u_big (
    .clk(clk), .reset(reset),
    .read_address_from_readout_comm(addr), .wea_from_readout_comm(wea),
    .read_block_o(b_block), .read_strobe_o(b_strobe), .read_remaining_o(b_rem),
    .read_done_i(done), .free_address_o(b_free_addr), .free_strobe_o(b_free_strobe),
    .full_o(b_full), .empty_o(b_empty), .count_o(b_count), .overflow_o(b_ovf),
    .state_debug_o(b_state)
  );

  readout_queue_v3 #(.DEPTH_LOG2(DLS)) u_small (
    .clk(clk), .reset(reset),
    .read_address_from_readout_comm(addr), .wea_from_readout_comm(wea),
    .read_block_o(s_block), .read_strobe_o(s_strobe), .read_remaining_o(s_rem),
    .read_done_i(done), .free_address_o(s_free_addr), .free_strobe_o(s_free_strobe),
    .full_o(s_full), .empty_o(s_empty), .count_o(s_count), .overflow_o(s_ovf),
    .state_debug_o(s_state)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    wea   = 1'b0;
    done  = 1'b0;
    step();
    reset = 1'b0;
  endtask

  // Hold read_done_i until both queues are empty and idle, then let the
  // final free pulse go by.
  task automatic drain(input string tag);
    int k;
    k = 0;
    done = 1'b1;
    while (!(b_empty === 1'b1 && s_empty === 1'b1 && b_state === 3'd0 && s_state === 3'd0)
           && k < 3000) begin
      step();
      k++;
    end
    chk(tag, (k < 3000), 1);
    step();
    step();
    done = 1'b0;
  endtask

  // ---------------- reference model / scoreboard (default instance) ----------------
  // The model is a plain queue of accepted entries plus an occupancy number.
  // A readout is in progress from the visible read strobe until read_done_i
  // is seen; the next cycle is the release, in which a slot is freed and an
  // enqueue is accepted even if the queue is full.
  logic [RW-1:0] m_q[$];
  logic [BW-1:0] exp_q[$];
  int            m_cnt      = 0;
  int            m_cnt_prev = 0;
  bit            m_busy     = 1'b0;
  bit            m_rel_next = 1'b0;
  bit            m_ovf      = 1'b0;

  always @(posedge clk) begin
    bit            rel_now;
    bit            acc;
    logic [RW-1:0] head;
    logic [BW-1:0] fexp;
    if (reset) begin
      m_q.delete();
      exp_q.delete();
      m_cnt      = 0;
      m_cnt_prev = 0;
      m_busy     = 1'b0;
      m_rel_next = 1'b0;
      m_ovf      = 1'b0;
    end else begin
      chk("mdl_count", b_count, m_cnt);
      chk("mdl_empty", b_empty, (m_cnt == 0));
      chk("mdl_full", b_full, (m_cnt == BIG_DEPTH));
      chk("mdl_overflow", b_ovf, m_ovf);
      if (b_free_strobe === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("mdl_free_unexpected", b_free_strobe, 0);
        end else begin
          fexp = exp_q.pop_front();
          chk("mdl_free_addr", b_free_addr, fexp);
        end
      end
      if (b_strobe === 1'b1) begin
        if (m_q.size() == 0 || m_busy) begin
          chk("mdl_strobe_unexpected", b_strobe, 0);
        end else begin
          chk("mdl_read_block", b_block, m_q[0]);
          chk("mdl_remaining", b_rem, (m_cnt_prev > 1));
        end
        m_busy = 1'b1;
      end
      rel_now    = m_rel_next;
      m_rel_next = 1'b0;
      acc        = wea && ((m_cnt < BIG_DEPTH) || rel_now);
      if (wea && !acc) m_ovf = 1'b1;
      m_cnt_prev = m_cnt;
      if (rel_now) begin
        head = m_q.pop_front();
        exp_q.push_back(head[BW-1:0]);
        m_cnt--;
        m_busy = 1'b0;
      end
      if (acc) begin
        m_q.push_back(addr);
        m_cnt++;
      end
      if (m_busy && done) m_rel_next = 1'b1;
    end
  end

  // Strobed entries of the depth-4 instance, in order.
  logic [RW-1:0] s_obs_q[$];
  always @(posedge clk) begin
    if (!reset && s_strobe === 1'b1) s_obs_q.push_back(s_block);
  end

  // Global time limit.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [RW-1:0] burst [3];
    logic [RW-1:0] f [5];
    logic [RW-1:0] w [10];
    logic [RW-1:0] g;
    int st_c [3];
    logic [RW-1:0] st_b [3];
    logic st_r [3];
    int fr_c [3];
    logic [BW-1:0] fr_a [3];
    int n_st, n_fr, k;

    wea = 1'b0; done = 1'b0; addr = '0; reset = 1'b1;
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_count", b_count, 0);
    chk("rst_empty", b_empty, 1);
    chk("rst_full", b_full, 0);
    chk("rst_state", b_state, 0);
    chk("rst_strobe", b_strobe, 0);
    chk("rst_free_strobe", b_free_strobe, 0);
    chk("rst_block", b_block, 0);
    chk("rst_free_addr", b_free_addr, 0);
    chk("rst_remaining", b_rem, 0);
    chk("rst_overflow", b_ovf, 0);
    chk("rst_s_empty", s_empty, 1);
    chk("rst_s_state", s_state, 0);

    // Single entry: strobe 4 cycles after the enqueue, done 3 cycles later.
    addr = 28'h0ABC123; wea = 1'b1;
    step();                          // t+1
    wea = 1'b0;
    chk("t1_count", b_count, 1);
    chk("t1_empty", b_empty, 0);
    step();                          // t+2
    chk("t1_fetch_state", b_state, 1);
    step();                          // t+3
    chk("t1_strobe_state", b_state, 2);
    chk("t1_no_early_strobe", b_strobe, 0);
    step();                          // t+4
    chk("t1_strobe", b_strobe, 1);
    chk("t1_block", b_block, 28'h0ABC123);
    chk("t1_remaining", b_rem, 0);
    chk("t1_wait_state", b_state, 3);
    step();                          // t+5
    chk("t1_strobe_pulse", b_strobe, 0);
    chk("t1_block_hold", b_block, 28'h0ABC123);
    step();                          // t+6
    step();                          // t+7
    done = 1'b1;
    step();                          // t+8
    done = 1'b0;
    chk("t1_release_state", b_state, 4);
    step();                          // t+9
    chk("t1_free_strobe", b_free_strobe, 1);
    chk("t1_free_addr", b_free_addr, 9'h123);
    chk("t1_empty_after", b_empty, 1);
    step();                          // t+10
    chk("t1_free_pulse", b_free_strobe, 0);
    chk("t1_idle", b_state, 0);

    // Burst of three with read_done_i held high.
    for (int i = 0; i < 3; i++) burst[i] = {19'($urandom), 9'(16 + i)};
    n_st = 0; n_fr = 0;
    done = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      if (c < 3) begin wea = 1'b1; addr = burst[c]; end
      else wea = 1'b0;
      if (b_strobe === 1'b1) begin
        if (n_st < 3) begin st_c[n_st] = c; st_b[n_st] = b_block; st_r[n_st] = b_rem; end
        n_st++;
      end
      if (b_free_strobe === 1'b1) begin
        if (n_fr < 3) begin fr_c[n_fr] = c; fr_a[n_fr] = b_free_addr; end
        n_fr++;
      end
      step();
    end
    done = 1'b0;
    chk("t2_n_strobes", n_st, 3);
    chk("t2_n_frees", n_fr, 3);
    if (n_st >= 3 && n_fr >= 3) begin
      for (int i = 0; i < 3; i++) begin
        chk("t2_strobe_cycle", st_c[i], 4 + 5 * i);
        chk("t2_block", st_b[i], burst[i]);
        chk("t2_remaining", st_r[i], (i < 2));
        chk("t2_free_cycle", fr_c[i], 6 + 5 * i);
        chk("t2_free_addr", fr_a[i], 16 + i);
      end
    end

    // Depth 4: fill, overflow on the fifth, drain keeps overflow sticky.
    do_reset();
    s_obs_q.delete();
    for (int i = 0; i < 5; i++) f[i] = RW'($urandom);
    for (int i = 0; i < 5; i++) begin
      wea = 1'b1; addr = f[i];
      step();
      if (i == 3) begin
        chk("t3_count4", s_count, 4);
        chk("t3_full", s_full, 1);
        chk("t3_no_ovf_yet", s_ovf, 0);
      end
    end
    wea = 1'b0;
    chk("t3_count_after_drop", s_count, 4);
    chk("t3_overflow", s_ovf, 1);
    drain("t3_drain_timeout");
    chk("t3_overflow_sticky", s_ovf, 1);
    chk("t3_empty", s_empty, 1);
    chk("t3_n_read", s_obs_q.size(), 4);
    for (int i = 0; i < 4 && i < s_obs_q.size(); i++) chk("t3_order", s_obs_q[i], f[i]);

    // Depth 4: enqueue coinciding with release while full.
    do_reset();
    chk("t4_ovf_cleared", s_ovf, 0);
    s_obs_q.delete();
    for (int i = 0; i < 4; i++) begin
      wea = 1'b1; addr = f[i];
      step();
    end
    wea = 1'b0;
    k = 0;
    while (s_state !== 3'd3 && k < 20) begin step(); k++; end
    chk("t4_wait_timeout", (k < 20), 1);
    chk("t4_full", s_full, 1);
    done = 1'b1;
    step();
    done = 1'b0;
    chk("t4_release_state", s_state, 4);
    g = RW'($urandom);
    wea = 1'b1; addr = g;
    step();
    wea = 1'b0;
    chk("t4_count_stays", s_count, 4);
    chk("t4_full_stays", s_full, 1);
    chk("t4_no_overflow", s_ovf, 0);
    drain("t4_drain_timeout");
    chk("t4_n_read", s_obs_q.size(), 5);
    for (int i = 0; i < 5 && i < s_obs_q.size(); i++)
      chk("t4_order", s_obs_q[i], (i < 4) ? f[i] : g);

    // Depth 4: ten entries through four slots to exercise pointer wrap.
    do_reset();
    s_obs_q.delete();
    done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      w[i] = RW'($urandom);
      wea = 1'b1; addr = w[i];
      step();
      wea = 1'b0;
      repeat ($urandom_range(4, 7)) step();
    end
    drain("t5_drain_timeout");
    chk("t5_no_overflow", s_ovf, 0);
    chk("t5_n_read", s_obs_q.size(), 10);
    for (int i = 0; i < 10 && i < s_obs_q.size(); i++) chk("t5_order", s_obs_q[i], w[i]);

    // Random traffic on the default instance, checked by the model.
    do_reset();
    for (int c = 0; c < 300; c++) begin
      wea  = ($urandom_range(0, 4) == 0);
      addr = RW'($urandom);
      done = 1'(($urandom_range(0, 1)));
      step();
    end
    wea = 1'b0;
    drain("rnd_drain_timeout");
    chk("rnd_all_freed", exp_q.size(), 0);

    // Reset while waiting for readout with three entries queued.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wea = 1'b1; addr = RW'($urandom);
      step();
    end
    wea = 1'b0;
    k = 0;
    while (b_state !== 3'd3 && k < 20) begin step(); k++; end
    chk("t6_wait_timeout", (k < 20), 1);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_no_free", b_free_strobe, 0);
    chk("t6_state", b_state, 0);
    chk("t6_count", b_count, 0);
    chk("t6_empty", b_empty, 1);
    chk("t6_s_count", s_count, 0);
    done = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      chk("t6_idle_after_done", b_state, 0);
      chk("t6_no_strobe", b_strobe, 0);
      chk("t6_no_free_after", b_free_strobe, 0);
    end
    done = 1'b0;
    chk("t6_model_clear", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
